// File: rtl/probe_modport_if.sv
// rtl/probe_modport_if.sv - host/core sideband bundle for probe_modport
// Optional PROBE_ALERT_CNT_EN adds the alert counter outputs.
interface probe_modport_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic             stop_i;
  logic             clr_i;
  logic             dbg_trig_i;
  logic             core_sleep_i;
  logic             alert_minor_i;
  logic             alert_major_i;
  logic             ecall_i;
  logic             fetch_enable_o;
  logic             debug_req_o;
  logic [1:0]       state_o;
  logic             minor_seen_o;
  logic             major_seen_o;
  logic             ecall_seen_o;
  logic             sleep_o;
  logic [CNT_W-1:0] ecall_cnt_o;
`ifdef PROBE_ALERT_CNT_EN
  logic [CNT_W-1:0] minor_cnt_o;
  logic [CNT_W-1:0] major_cnt_o;
`endif

  modport master (
    output start_i, stop_i, clr_i, dbg_trig_i,
           core_sleep_i, alert_minor_i, alert_major_i, ecall_i,
    input  fetch_enable_o, debug_req_o, state_o,
           minor_seen_o, major_seen_o, ecall_seen_o, sleep_o, ecall_cnt_o
`ifdef PROBE_ALERT_CNT_EN
    , input minor_cnt_o, major_cnt_o
`endif
  );

  modport slave (
    input  start_i, stop_i, clr_i, dbg_trig_i,
           core_sleep_i, alert_minor_i, alert_major_i, ecall_i,
    output fetch_enable_o, debug_req_o, state_o,
           minor_seen_o, major_seen_o, ecall_seen_o, sleep_o, ecall_cnt_o
`ifdef PROBE_ALERT_CNT_EN
    , output minor_cnt_o, major_cnt_o
`endif
  );
endinterface

// File: rtl/probe_modport.sv
// rtl/probe_modport.sv - run-control FSM, sticky flags and event counters for core sideband
// Optional PROBE_ALERT_CNT_EN adds rising-edge counters for the minor/major alerts.
module probe_modport #(
  parameter int CNT_W         = 16,
  parameter int DBG_PULSE     = 4,
  parameter int STOP_ON_ECALL = 1
) (
  input logic           clk,
  input logic           rst_n,
  probe_modport_if.slave bus
);
  localparam int DW = $clog2(DBG_PULSE + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DONE  = 2'b10,
    ST_FAULT = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    dbg_cnt_q, dbg_cnt_d;
  logic             trig_q, ecall_q, sleep_q;
  logic             minor_seen_q, minor_seen_d;
  logic             major_seen_q, major_seen_d;
  logic             ecall_seen_q, ecall_seen_d;
  logic [CNT_W-1:0] ecall_cnt_q, ecall_cnt_d;
  logic             trig_rise, ecall_rise;
`ifdef PROBE_ALERT_CNT_EN
  logic             minor_q, major_q;
  logic [CNT_W-1:0] minor_cnt_q, minor_cnt_d;
  logic [CNT_W-1:0] major_cnt_q, major_cnt_d;
`endif

  // Saturating increment; clear has priority over the increment.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic clr);
    if (clr)
      return '0;
    else if (inc && (c != {CNT_W{1'b1}}))
      return c + 1'b1;
    else
      return c;
  endfunction

  assign trig_rise  = bus.dbg_trig_i & ~trig_q;
  assign ecall_rise = bus.ecall_i & ~ecall_q;

  always_comb begin
    state_d      = state_q;
    dbg_cnt_d    = dbg_cnt_q;
    minor_seen_d = bus.clr_i ? 1'b0 : (minor_seen_q | bus.alert_minor_i);
    major_seen_d = bus.clr_i ? 1'b0 : (major_seen_q | bus.alert_major_i);
    ecall_seen_d = bus.clr_i ? 1'b0 : (ecall_seen_q | bus.ecall_i);
    ecall_cnt_d  = cnt_next(ecall_cnt_q, ecall_rise, bus.clr_i);
`ifdef PROBE_ALERT_CNT_EN
    minor_cnt_d  = cnt_next(minor_cnt_q, bus.alert_minor_i & ~minor_q, bus.clr_i);
    major_cnt_d  = cnt_next(major_cnt_q, bus.alert_major_i & ~major_q, bus.clr_i);
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i)
          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.alert_major_i)
          state_d = ST_FAULT;
        else if (bus.stop_i)
          state_d = ST_IDLE;
        else if (ecall_rise && (STOP_ON_ECALL != 0))
          state_d = ST_DONE;
      end
      default: begin
        if (bus.clr_i)
          state_d = ST_IDLE;
      end
    endcase

    // Pulse is cut in the same cycle the FSM leaves RUN.
    if (state_d != ST_RUN)
      dbg_cnt_d = '0;
    else if (dbg_cnt_q != '0)
      dbg_cnt_d = dbg_cnt_q - 1'b1;
    else if ((state_q == ST_RUN) && trig_rise)
      dbg_cnt_d = DW'(DBG_PULSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dbg_cnt_q    <= '0;
      trig_q       <= 1'b0;
      ecall_q      <= 1'b0;
      sleep_q      <= 1'b0;
      minor_seen_q <= 1'b0;
      major_seen_q <= 1'b0;
      ecall_seen_q <= 1'b0;
      ecall_cnt_q  <= '0;
`ifdef PROBE_ALERT_CNT_EN
      minor_q      <= 1'b0;
      major_q      <= 1'b0;
      minor_cnt_q  <= '0;
      major_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dbg_cnt_q    <= dbg_cnt_d;
      trig_q       <= bus.dbg_trig_i;
      ecall_q      <= bus.ecall_i;
      sleep_q      <= bus.core_sleep_i;
      minor_seen_q <= minor_seen_d;
      major_seen_q <= major_seen_d;
      ecall_seen_q <= ecall_seen_d;
      ecall_cnt_q  <= ecall_cnt_d;
`ifdef PROBE_ALERT_CNT_EN
      minor_q      <= bus.alert_minor_i;
      major_q      <= bus.alert_major_i;
      minor_cnt_q  <= minor_cnt_d;
      major_cnt_q  <= major_cnt_d;
`endif
    end
  end

  assign bus.fetch_enable_o = (state_q == ST_RUN);
  assign bus.debug_req_o    = (dbg_cnt_q != '0);
  assign bus.state_o        = state_q;
  assign bus.minor_seen_o   = minor_seen_q;
  assign bus.major_seen_o   = major_seen_q;
  assign bus.ecall_seen_o   = ecall_seen_q;
  assign bus.sleep_o        = sleep_q;
  assign bus.ecall_cnt_o    = ecall_cnt_q;
`ifdef PROBE_ALERT_CNT_EN
  assign bus.minor_cnt_o    = minor_cnt_q;
  assign bus.major_cnt_o    = major_cnt_q;
`endif
endmodule

// File: tb/tb_probe_modport.sv
// tb/tb_probe_modport.sv - directed self-checking bench for probe_modport
// u0: STOP_ON_ECALL=0, u1: STOP_ON_ECALL=1, u2: CNT_W=2; PROBE_ALERT_CNT_EN adds alert counter checks.
module tb_probe_modport;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  probe_modport_if #(.CNT_W(16)) b0();
  probe_modport_if #(.CNT_W(16)) b1();
  probe_modport_if #(.CNT_W(2))  b2();

  probe_modport #(.CNT_W(16), .DBG_PULSE(4), .STOP_ON_ECALL(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  probe_modport #(.CNT_W(16), .DBG_PULSE(4), .STOP_ON_ECALL(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  probe_modport #(.CNT_W(2),  .DBG_PULSE(4), .STOP_ON_ECALL(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    b0.start_i = 0; b0.stop_i = 0; b0.clr_i = 0; b0.dbg_trig_i = 0;
    b0.core_sleep_i = 0; b0.alert_minor_i = 0; b0.alert_major_i = 0; b0.ecall_i = 0;
    b1.start_i = 0; b1.stop_i = 0; b1.clr_i = 0; b1.dbg_trig_i = 0;
    b1.core_sleep_i = 0; b1.alert_minor_i = 0; b1.alert_major_i = 0; b1.ecall_i = 0;
    b2.start_i = 0; b2.stop_i = 0; b2.clr_i = 0; b2.dbg_trig_i = 0;
    b2.core_sleep_i = 0; b2.alert_minor_i = 0; b2.alert_major_i = 0; b2.ecall_i = 0;
  endtask

  task automatic test_reset();
    logic [23:0] got;
    zero_inputs();
    rst_n = 1'b0;
    tick(); tick();
    got = {b0.state_o, b0.fetch_enable_o, b0.debug_req_o, b0.minor_seen_o, b0.major_seen_o,
           b0.ecall_seen_o, b0.sleep_o, b0.ecall_cnt_o};
    checks++;
    if (got !== 24'h0) begin
      failures++; $display("FAIL reset_u0 got=%h exp=000000", got);
    end
    checks++;
    if ({b1.state_o, b1.fetch_enable_o, b2.ecall_cnt_o} !== 5'b0) begin
      failures++; $display("FAIL reset_u1u2 got=%b exp=00000", {b1.state_o, b1.fetch_enable_o, b2.ecall_cnt_o});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_start();
    b0.start_i = 1; tick(); b0.start_i = 0;
    checks++;
    if ({b0.state_o, b0.fetch_enable_o, b0.debug_req_o} !== 4'b0110) begin
      failures++; $display("FAIL start got=%b exp=0110", {b0.state_o, b0.fetch_enable_o, b0.debug_req_o});
    end
  endtask

  task automatic test_sleep();
    b0.core_sleep_i = 1; tick();
    checks++;
    if ({b0.sleep_o, b0.state_o} !== 3'b101) begin
      failures++; $display("FAIL sleep_hi got=%b exp=101", {b0.sleep_o, b0.state_o});
    end
    b0.core_sleep_i = 0; tick();
    checks++;
    if (b0.sleep_o !== 1'b0) begin
      failures++; $display("FAIL sleep_lo got=%b exp=0", b0.sleep_o);
    end
  endtask

  task automatic test_debug_pulse();
    int highs = 0;
    int rises = 0;
    logic prev = 1'b0;
    b0.dbg_trig_i = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (b0.debug_req_o === 1'b1) highs++;
      if (b0.debug_req_o === 1'b1 && !prev) rises++;
      prev = b0.debug_req_o;
    end
    b0.dbg_trig_i = 0; tick();
    checks++;
    if (highs !== 4) begin
      failures++; $display("FAIL dbg_len got=%0d exp=4", highs);
    end
    checks++;
    if (rises !== 1) begin
      failures++; $display("FAIL dbg_pulses got=%0d exp=1", rises);
    end
  endtask

  task automatic test_ecall_count();
    for (int i = 0; i < 3; i++) begin
      b0.ecall_i = 1; tick(); b0.ecall_i = 0; tick();
    end
    checks++;
    if (b0.ecall_cnt_o !== 16'd3) begin
      failures++; $display("FAIL ecall_cnt got=%0d exp=3", b0.ecall_cnt_o);
    end
    checks++;
    if ({b0.ecall_seen_o, b0.state_o} !== 3'b101) begin
      failures++; $display("FAIL ecall_nostop got=%b exp=101", {b0.ecall_seen_o, b0.state_o});
    end
  endtask

  task automatic test_alert_cnt();
`ifdef PROBE_ALERT_CNT_EN
    for (int i = 0; i < 2; i++) begin
      b0.alert_minor_i = 1; tick(); b0.alert_minor_i = 0; tick();
    end
    checks++;
    if (b0.minor_cnt_o !== 16'd2) begin
      failures++; $display("FAIL minor_cnt got=%0d exp=2", b0.minor_cnt_o);
    end
    checks++;
    if ({b0.minor_seen_o, b0.state_o, b0.major_cnt_o} !== 19'b1_01_0000000000000000) begin
      failures++; $display("FAIL minor_side got=%b exp=1010000000000000000",
                           {b0.minor_seen_o, b0.state_o, b0.major_cnt_o});
    end
`endif
  endtask

  task automatic test_stop_and_idle_trig();
    b0.stop_i = 1; tick(); b0.stop_i = 0;
    checks++;
    if ({b0.state_o, b0.fetch_enable_o} !== 3'b000) begin
      failures++; $display("FAIL stop got=%b exp=000", {b0.state_o, b0.fetch_enable_o});
    end
    b0.dbg_trig_i = 1; tick();
    checks++;
    if (b0.debug_req_o !== 1'b0) begin
      failures++; $display("FAIL idle_trig got=%b exp=0", b0.debug_req_o);
    end
    b0.dbg_trig_i = 0; tick();
    b0.start_i = 1; tick(); b0.start_i = 0;
  endtask

  task automatic test_fault();
    b0.dbg_trig_i = 1; tick(); b0.dbg_trig_i = 0;
    checks++;
    if (b0.debug_req_o !== 1'b1) begin
      failures++; $display("FAIL fault_pre_dbg got=%b exp=1", b0.debug_req_o);
    end
    b0.alert_major_i = 1; b0.stop_i = 1; tick();
    b0.alert_major_i = 0; b0.stop_i = 0;
    checks++;
    if ({b0.state_o, b0.fetch_enable_o, b0.debug_req_o, b0.major_seen_o} !== 5'b11001) begin
      failures++; $display("FAIL fault got=%b exp=11001",
                           {b0.state_o, b0.fetch_enable_o, b0.debug_req_o, b0.major_seen_o});
    end
    b0.start_i = 1; tick(); b0.stop_i = 1; tick(); b0.start_i = 0; b0.stop_i = 0;
    checks++;
    if ({b0.state_o, b0.fetch_enable_o} !== 3'b110) begin
      failures++; $display("FAIL fault_hold got=%b exp=110", {b0.state_o, b0.fetch_enable_o});
    end
    b0.clr_i = 1; tick(); b0.clr_i = 0;
    checks++;
    if ({b0.state_o, b0.minor_seen_o, b0.major_seen_o, b0.ecall_seen_o, b0.ecall_cnt_o} !== 21'h0) begin
      failures++; $display("FAIL fault_clr got=%b exp=0",
                           {b0.state_o, b0.minor_seen_o, b0.major_seen_o, b0.ecall_seen_o, b0.ecall_cnt_o});
    end
  endtask

  task automatic test_stop_on_ecall();
    b1.start_i = 1; tick(); b1.start_i = 0;
    b1.ecall_i = 1; tick(); b1.ecall_i = 0;
    checks++;
    if ({b1.state_o, b1.fetch_enable_o, b1.ecall_cnt_o} !== {2'b10, 1'b0, 16'd1}) begin
      failures++; $display("FAIL ecall_done got=%b exp=1000000000000000001",
                           {b1.state_o, b1.fetch_enable_o, b1.ecall_cnt_o});
    end
    b1.start_i = 1; tick(); b1.start_i = 0;
    checks++;
    if (b1.state_o !== 2'b10) begin
      failures++; $display("FAIL done_hold got=%b exp=10", b1.state_o);
    end
    b1.clr_i = 1; tick(); b1.clr_i = 0;
    checks++;
    if ({b1.state_o, b1.ecall_seen_o} !== 3'b000) begin
      failures++; $display("FAIL done_clr got=%b exp=000", {b1.state_o, b1.ecall_seen_o});
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin
      b2.ecall_i = 1; tick(); b2.ecall_i = 0; tick();
    end
    checks++;
    if (b2.ecall_cnt_o !== 2'd3) begin
      failures++; $display("FAIL sat got=%0d exp=3", b2.ecall_cnt_o);
    end
    b2.ecall_i = 1; b2.clr_i = 1; tick(); b2.ecall_i = 0; b2.clr_i = 0;
    checks++;
    if ({b2.ecall_cnt_o, b2.ecall_seen_o} !== 3'b000) begin
      failures++; $display("FAIL clr_vs_edge got=%b exp=000", {b2.ecall_cnt_o, b2.ecall_seen_o});
    end
  endtask

  task automatic test_back_to_back_reset();
    b0.start_i = 1; tick(); b0.start_i = 0;
    b0.ecall_i = 1; tick(); b0.ecall_i = 0;
    b0.dbg_trig_i = 1; tick(); b0.dbg_trig_i = 0;
    checks++;
    if ({b0.debug_req_o, b0.ecall_cnt_o} !== {1'b1, 16'd1}) begin
      failures++; $display("FAIL pre_rst got=%b exp=10000000000000001", {b0.debug_req_o, b0.ecall_cnt_o});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b0.state_o, b0.fetch_enable_o, b0.debug_req_o, b0.ecall_seen_o, b0.ecall_cnt_o} !== 21'h0) begin
      failures++; $display("FAIL async_rst got=%b exp=0",
                           {b0.state_o, b0.fetch_enable_o, b0.debug_req_o, b0.ecall_seen_o, b0.ecall_cnt_o});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_start();
    test_sleep();
    test_debug_pulse();
    test_ecall_count();
    test_alert_cnt();
    test_stop_and_idle_trig();
    test_fault();
    test_stop_on_ecall();
    test_saturate();
    test_back_to_back_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
